// File: rtl/seq_multiplier.sv
// Sequential signed multiplier using radix-2 Booth recoding.
// One iteration per clock; a WIDTH-bit result is ready WIDTH cycles after the load edge.
module seq_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_start,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int unsigned PW   = 2 * WIDTH + 2;
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           r_state;
  logic [PW-1:0]    r_prod;
  logic [WIDTH-1:0] r_a;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_exc;
  logic             r_rdy;

  logic [WIDTH:0]   w_acc;
  logic [WIDTH:0]   w_a_ext;
  logic [WIDTH:0]   w_sum;
  logic [PW-1:0]    w_next;
  logic [WIDTH:0]   w_hi;
  logic             w_exc;

  // Product register layout: {accumulator[WIDTH:0], multiplier[WIDTH-1:0], guard}.
  always_comb begin
    w_acc   = r_prod[PW-1:WIDTH+1];
    w_a_ext = {r_a[WIDTH-1], r_a};
    unique case (r_prod[1:0])
      2'b01:   w_sum = w_acc + w_a_ext;
      2'b10:   w_sum = w_acc - w_a_ext;
      default: w_sum = w_acc;
    endcase
    w_next = {w_sum[WIDTH], w_sum, r_prod[WIDTH:1]};
    // Product bit i sits at register bit i+1; bits [2W-1:W-1] must all match the sign.
    w_hi   = w_next[2*WIDTH:WIDTH];
    w_exc  = !((&w_hi) || !(|w_hi));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= StIdle;
      r_prod   <= '0;
      r_a      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      unique case (r_state)
        StIdle, StDone: begin
          if (ctrl_start) begin
            r_a     <= data_operandA;
            r_prod  <= {{(WIDTH + 1){1'b0}}, data_operandB, 1'b0};
            r_cnt   <= '0;
            r_state <= StBusy;
          end else begin
            r_state <= StIdle;
          end
        end
        StBusy: begin
          r_prod <= w_next;
          r_cnt  <= r_cnt + CntW'(1);
          if (r_cnt == CntLast) begin
            r_state  <= StDone;
            r_rdy    <= 1'b1;
            r_result <= w_next[WIDTH:1];
            r_exc    <= w_exc;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed vector table, randomized operands
// against a plain-arithmetic signed product model, and multi-cycle corner sequences.
module tb_seq_multiplier;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         ctrl_start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] res;
  logic         exc;
  logic         rdy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         exc;
  } vec_t;

  vec_t tbl[10];

  always #5 clock = ~clock;

  seq_multiplier #(.WIDTH(W)) dut (
    .clock         (clock),
    .reset         (reset),
    .ctrl_start    (ctrl_start),
    .data_operandA (op_a),
    .data_operandB (op_b),
    .data_result   (res),
    .data_exception(exc),
    .data_resultRDY(rdy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Full signed product, then truncate; exception when it leaves the WIDTH-bit signed range.
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic e);
    longint p;
    longint lim;
    p   = longint'($signed(x)) * longint'($signed(y));
    lim = longint'(1) <<< (W - 1);
    r   = p[W-1:0];
    e   = (p >= lim) || (p < -lim);
  endfunction

  // Returns how many rising edges after the current point until RDY is seen, -1 on timeout.
  task automatic wait_rdy(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clock);
      if (rdy === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic count_rdy(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (rdy !== 1'b0) pulses++;
    end
  endtask

  // Ends just after the load edge, with the operand inputs scrambled.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    ctrl_start = 1'b1;
    op_a       = a;
    op_b       = b;
    @(negedge clock);
    ctrl_start = 1'b0;
    op_a       = $urandom;
    op_b       = $urandom;
  endtask

  task automatic run_vec(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic ee);
    int cyc;
    start_op(a, b);
    wait_rdy(cyc);
    chk({name, " latency"}, 64'(cyc), 64'(W));
    chk({name, " result"}, 64'(res), 64'(er));
    chk({name, " exception"}, 64'(exc), 64'(ee));
    @(negedge clock);
    chk({name, " rdy width"}, 64'(rdy), 64'd0);
    chk({name, " result held"}, 64'(res), 64'(er));
  endtask

  initial begin
    logic [W-1:0] ra, rb, er;
    logic         ee;
    logic [W-1:0] corners[4];
    int           cyc;
    int           pulses;

    tbl[0] = '{32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 1'b0};
    tbl[1] = '{32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFD6, 1'b0};
    tbl[2] = '{32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0};
    tbl[3] = '{32'h7FFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 1'b1};
    tbl[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    tbl[5] = '{32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 1'b0};
    tbl[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
    tbl[7] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
    tbl[8] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
    tbl[9] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 1'b1};

    corners[0] = 32'h0000_0000;
    corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h8000_0000;
    corners[3] = 32'h7FFF_FFFF;

    // Reset with start also asserted: reset must win.
    reset      = 1'b1;
    ctrl_start = 1'b1;
    op_a       = 32'd3;
    op_b       = 32'd5;
    @(negedge clock);
    @(negedge clock);
    chk("reset result", 64'(res), 64'd0);
    chk("reset exception", 64'(exc), 64'd0);
    chk("reset rdy", 64'(rdy), 64'd0);
    reset      = 1'b0;
    ctrl_start = 1'b0;
    count_rdy(W + 3, pulses);
    chk("reset beats start", 64'(pulses), 64'd0);

    for (int i = 0; i < 10; i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].exc);
    end

    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(3) == 0) ? corners[$urandom_range(3)] : W'($urandom);
      rb = ($urandom_range(3) == 0) ? corners[$urandom_range(3)] : W'($urandom);
      model(ra, rb, er, ee);
      run_vec($sformatf("rand%0d", i), ra, rb, er, ee);
    end

    // Start pulsed mid-operation with new operands must be ignored.
    start_op(32'd4, 32'd4);
    repeat (9) @(negedge clock);
    ctrl_start = 1'b1;
    op_a       = 32'd9;
    op_b       = 32'd9;
    @(negedge clock);
    ctrl_start = 1'b0;
    wait_rdy(cyc);
    chk("busy start latency", 64'(cyc), 64'(W - 10));
    chk("busy start result", 64'(res), 64'h10);
    chk("busy start exception", 64'(exc), 64'd0);
    count_rdy(W + 5, pulses);
    chk("busy start single rdy", 64'(pulses), 64'd0);

    // Reset in the middle of an operation abandons it.
    start_op(32'd5, 32'd7);
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midreset result", 64'(res), 64'd0);
    chk("midreset exception", 64'(exc), 64'd0);
    chk("midreset rdy", 64'(rdy), 64'd0);
    reset = 1'b0;
    count_rdy(W + 5, pulses);
    chk("midreset no rdy", 64'(pulses), 64'd0);
    run_vec("after reset", 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 1'b0);

    // Start held high: back-to-back operations every WIDTH+1 cycles.
    @(negedge clock);
    ctrl_start = 1'b1;
    op_a       = '1;
    op_b       = '1;
    for (int k = 0; k < 4; k++) begin
      wait_rdy(cyc);
      chk($sformatf("b2b%0d period", k), 64'(cyc), 64'(W + 1));
      chk($sformatf("b2b%0d result", k), 64'(res), 64'd1);
      chk($sformatf("b2b%0d exception", k), 64'(exc), 64'd0);
    end
    @(negedge clock);
    chk("b2b rdy width", 64'(rdy), 64'd0);
    ctrl_start = 1'b0;
    @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
